// File: rtl/stopwatch_sseg.sv
// M.SS.t decimal stopwatch driving four registered seven-segment patterns.
// Optional lap-freeze display is built when SSW_LAP_EN is defined.
module stopwatch_sseg #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       clr,
    input  logic       lap,
    output logic [7:0] sseg3,
    output logic [7:0] sseg2,
    output logic [7:0] sseg1,
    output logic [7:0] sseg0,
    output logic       running,
    output logic       wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    logic [PW-1:0]   ps_q, ps_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0][3:0] view;
    logic [3:0][7:0] seg_q, seg_d;
    logic            running_q, running_d;
    logic            wrap_q, wrap_d;
    logic            tick, c1, c2, c3, c4;

    always_comb begin
        tick  = go && (ps_q == PS_LAST);
        c1    = tick && (dig_q[0] == 4'd9);
        c2    = c1 && (dig_q[1] == 4'd9);
        c3    = c2 && (dig_q[2] == 4'd5);
        c4    = c3 && (dig_q[3] == 4'd9);
        ps_d  = ps_q;
        dig_d = dig_q;
        if (go) ps_d = tick ? '0 : ps_q + 1'b1;
        if (tick) dig_d[0] = c1 ? 4'd0 : dig_q[0] + 4'd1;
        if (c1) dig_d[1] = c2 ? 4'd0 : dig_q[1] + 4'd1;
        if (c2) dig_d[2] = c3 ? 4'd0 : dig_q[2] + 4'd1;
        if (c3) dig_d[3] = c4 ? 4'd0 : dig_q[3] + 4'd1;
        wrap_d    = c4;
        running_d = go && !clr;
        // clear wins over any tick landing in the same cycle
        if (clr) begin
            ps_d   = '0;
            dig_d  = '0;
            wrap_d = 1'b0;
        end
    end

`ifdef SSW_LAP_EN
    logic            lap_q, lap_d;
    logic            frozen_q, frozen_d;
    logic [3:0][3:0] cap_q, cap_d;

    always_comb begin
        lap_d    = lap;
        frozen_d = frozen_q;
        cap_d    = cap_q;
        if (lap && !lap_q) begin
            frozen_d = !frozen_q;
            if (!frozen_q) cap_d = dig_q;
        end
        if (clr) frozen_d = 1'b0;
        view = frozen_q ? cap_q : dig_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q    <= 1'b0;
            frozen_q <= 1'b0;
            cap_q    <= '0;
        end else begin
            lap_q    <= lap_d;
            frozen_q <= frozen_d;
            cap_q    <= cap_d;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign view = dig_q;
`endif

    always_comb begin
        seg_d[3] = seg7(view[3]) & 8'h7F;
        seg_d[2] = seg7(view[2]);
        seg_d[1] = seg7(view[1]) & 8'h7F;
        seg_d[0] = seg7(view[0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q      <= '0;
            dig_q     <= '0;
            seg_q     <= {8'h40, 8'hC0, 8'h40, 8'hC0};
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign sseg3   = seg_q[3];
    assign sseg2   = seg_q[2];
    assign sseg1   = seg_q[1];
    assign sseg0   = seg_q[0];
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_sseg.sv
// Bench for stopwatch_sseg with a 4-cycle tick.
// Vector table plus wrap, lap and async-reset sequences.
module tb_stopwatch_sseg;

    logic       clk = 1'b0;
    logic       reset, go, clr, lap;
    logic [7:0] sseg3, sseg2, sseg1, sseg0;
    logic       running, wrap;

    stopwatch_sseg #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .go(go), .clr(clr), .lap(lap),
        .sseg3(sseg3), .sseg2(sseg2), .sseg1(sseg1), .sseg0(sseg0),
        .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] s3, s2, s1, s0;
        logic       run, wrp;
    } exp_t;

    typedef struct {
        logic go, clr;
        int   n;
        exp_t e;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   wrap_cnt = 0;
    vec_t vt[13];

    always @(negedge clk) if (wrap) wrap_cnt++;

    function automatic exp_t mk(input logic [31:0] s, input logic r,
                                input logic w);
        exp_t e;
        e.s3 = s[31:24]; e.s2 = s[23:16];
        e.s1 = s[15:8];  e.s0 = s[7:0];
        e.run = r; e.wrp = w;
        return e;
    endfunction

    task automatic push(input exp_t e);
        q.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e, a;
        a = {sseg3, sseg2, sseg1, sseg0, running, wrap};
        total++;
        if (q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %h", name, a);
            return;
        end
        e = q.pop_front();
        if (a === e) passed++;
        else $display("FAIL %s: got %h %h %h %h run=%b wrap=%b, need %h %h %h %h run=%b wrap=%b",
                      name, a.s3, a.s2, a.s1, a.s0, a.run, a.wrp,
                      e.s3, e.s2, e.s1, e.s0, e.run, e.wrp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_int(input string name, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d, need %0d", name, a, e);
    endtask

    initial begin
        vt[0]  = '{0, 0, 3,  mk(32'h40C040C0, 0, 0)};
        vt[1]  = '{1, 0, 40, mk(32'h40C04090, 1, 0)};
        vt[2]  = '{0, 0, 1,  mk(32'h40C079C0, 0, 0)};
        vt[3]  = '{1, 0, 2,  mk(32'h40C079C0, 1, 0)};
        vt[4]  = '{0, 0, 10, mk(32'h40C079C0, 0, 0)};
        vt[5]  = '{1, 0, 1,  mk(32'h40C079C0, 1, 0)};
        vt[6]  = '{1, 0, 1,  mk(32'h40C079C0, 1, 0)};
        vt[7]  = '{0, 0, 1,  mk(32'h40C079F9, 0, 0)};
        vt[8]  = '{1, 0, 3,  mk(32'h40C079F9, 1, 0)};
        vt[9]  = '{1, 1, 1,  mk(32'h40C079F9, 0, 0)};
        vt[10] = '{0, 0, 1,  mk(32'h40C040C0, 0, 0)};
        vt[11] = '{1, 0, 4,  mk(32'h40C040C0, 1, 0)};
        vt[12] = '{0, 0, 1,  mk(32'h40C040F9, 0, 0)};

        reset = 1'b0; go = 1'b0; clr = 1'b0; lap = 1'b0;
        cyc(3);
        reset = 1'b1;
        #1;
        push(mk(32'h40C040C0, 0, 0));
        pop_check("reset");

        @(negedge clk);
        foreach (vt[i]) begin
            go  = vt[i].go;
            clr = vt[i].clr;
            push(vt[i].e);
            cyc(vt[i].n);
            pop_check($sformatf("vec%0d", i));
        end

        // count up to 9:59.9 and roll over
        clr = 1'b1; go = 1'b0;
        cyc(1);
        clr = 1'b0; go = 1'b1;
        wrap_cnt = 0;
        cyc(5999 * 4);
        go = 1'b0;
        cyc(1);
        push(mk(32'h10921090, 0, 0));
        pop_check("at_9599");
        check_int("no_early_wrap", wrap_cnt, 0);
        go = 1'b1;
        cyc(4);
        push(mk(32'h10921090, 1, 1));
        pop_check("wrap_pulse");
        go = 1'b0;
        cyc(1);
        push(mk(32'h40C040C0, 0, 0));
        pop_check("after_wrap");
        cyc(4);
        check_int("wrap_once", wrap_cnt, 1);

        // lap freeze at 0:00.3, run 8 ticks, release
        clr = 1'b1;
        cyc(1);
        clr = 1'b0; go = 1'b1;
        cyc(12);
        go = 1'b0; lap = 1'b1;
        cyc(1);
        lap = 1'b0; go = 1'b1;
        cyc(32);
        go = 1'b0;
        cyc(1);
`ifdef SSW_LAP_EN
        push(mk(32'h40C040B0, 0, 0));
`else
        push(mk(32'h40C079F9, 0, 0));
`endif
        pop_check("lap_hold");
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
`ifdef SSW_LAP_EN
        push(mk(32'h40C040B0, 0, 0));
`else
        push(mk(32'h40C079F9, 0, 0));
`endif
        pop_check("lap_edge");
        cyc(1);
        push(mk(32'h40C079F9, 0, 0));
        pop_check("lap_release");

        // async reset mid-run
        go = 1'b1;
        cyc(6);
        #2 reset = 1'b0;
        #1;
        push(mk(32'h40C040C0, 0, 0));
        pop_check("async_reset");
        reset = 1'b1; go = 1'b0;
        cyc(2);
        push(mk(32'h40C040C0, 0, 0));
        pop_check("post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
